// File: rtl/mc_pkg.sv
// Shared definitions for the mc_control sequencer: opcodes, FSM states, IR field positions.
// Pure declarations; no timing or flow control.
package mc_pkg;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;

   localparam int OP_MSB     = 15;
   localparam int OP_LSB     = 13;
   localparam int RX_MSB     = 12;
   localparam int RX_LSB     = 10;
   localparam int RY_MSB     = 9;
   localparam int RY_LSB     = 7;
   localparam int ADDSUB_BIT = 13;

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to one-hot-8 decode with enable; all-zero when disabled.
// Purely combinational, zero latency, no flow control.
module dec3to8 (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] onehot
);

   assign onehot = en ? (8'b0000_0001 << sel) : 8'b0000_0000;

endmodule

// File: rtl/mc_control.sv
// Four-state control sequencer for a 16-bit, 8-register processor; MC_MVNZ_EN enables mvnz.
// mv/mvi/illegal take 2 cycles, add/sub 4; run is only accepted in T0 (ignored while busy).
module mc_control
   import mc_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   input  logic        run,
   input  logic [15:0] DIN,
   input  logic        G_cond_check,
   output logic        IR_load,
   output logic [7:0]  R_in,
   output logic [7:0]  R_out,
   output logic        DIN_out,
   output logic        A_in,
   output logic        G_write,
   output logic        G_out_en,
   output logic        addsub,
   output logic        done,
   output logic        busy
);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] ir;

   logic [2:0]  opcode;
   logic [2:0]  rx;
   logic [2:0]  ry;

   logic        rin_en;
   logic [2:0]  rin_sel;
   logic        rout_en;
   logic [2:0]  rout_sel;

   assign opcode = ir[OP_MSB:OP_LSB];
   assign rx     = ir[RX_MSB:RX_LSB];
   assign ry     = ir[RY_MSB:RY_LSB];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= T0;
         ir    <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (state == T0 && run) begin
            ir <= DIN;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         T0: state_nxt = run ? T1 : T0;
         T1: state_nxt = (opcode == OP_ADD || opcode == OP_SUB) ? T2 : T0;
         T2: state_nxt = T3;
         T3: state_nxt = T0;
         default: state_nxt = T0;
      endcase
   end

   always_comb begin
      IR_load  = 1'b0;
      DIN_out  = 1'b0;
      A_in     = 1'b0;
      G_write  = 1'b0;
      G_out_en = 1'b0;
      addsub   = 1'b0;
      done     = 1'b0;
      rin_en   = 1'b0;
      rin_sel  = rx;
      rout_en  = 1'b0;
      rout_sel = ry;
      case (state)
         T0: IR_load = run;
         T1: begin
            case (opcode)
               OP_MV: begin
                  rout_en = 1'b1;
                  rin_en  = 1'b1;
                  done    = 1'b1;
               end
               OP_MVI: begin
                  DIN_out = 1'b1;
                  rin_en  = 1'b1;
                  done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_sel = rx;
                  rout_en  = 1'b1;
                  A_in     = 1'b1;
               end
`ifdef MC_MVNZ_EN
               OP_MVNZ: begin
                  // G_cond_check=1 means G is zero, so the move is suppressed
                  rout_en = !G_cond_check;
                  rin_en  = !G_cond_check;
                  done    = 1'b1;
               end
`endif
               default: done = 1'b1;
            endcase
         end
         T2: begin
            rout_en = 1'b1;
            G_write = 1'b1;
            addsub  = ir[ADDSUB_BIT];
         end
         T3: begin
            G_out_en = 1'b1;
            rin_en   = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = (state != T0);

   dec3to8 u_dec_rin (
      .sel    (rin_sel),
      .en     (rin_en),
      .onehot (R_in)
   );

   dec3to8 u_dec_rout (
      .sel    (rout_sel),
      .en     (rout_en),
      .onehot (R_out)
   );

   // IR[6:0] carries no control information
`ifdef MC_MVNZ_EN
   logic unused_bits;
   assign unused_bits = ^ir[6:0];
`else
   logic unused_bits;
   assign unused_bits = ^{ir[6:0], G_cond_check};
`endif

endmodule
